// File: rtl/qtab_pkg.sv
// qtab_pkg: default quantisation table, zig-zag scan order and streamer states
package qtab_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [511:0] DEF_TAB = {
    64'hFF806C5D4F4C473C,
    64'h80805D554C473C37,
    64'h6C5D4F4C473C3C36,
    64'h5D5D4F4C473C3733,
    64'h5D4F4C47403B332B,
    64'h4F4C47403B332B23,
    64'h4F4C473C362D251E,
    64'h4C473B362D251E19
  };
  localparam logic [5:0] ZIGZAG [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };
  function automatic logic [7:0] def_val(input int a);
    return DEF_TAB[511-8*a -: 8];
  endfunction
endpackage

// File: rtl/qtab_mem.sv
// qtab_mem: multi-table coefficient store with reset defaults, one write and one async read port
module qtab_mem import qtab_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_TAB = 2,
  localparam int TAB_W = NUM_TAB > 1 ? $clog2(NUM_TAB) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [TAB_W-1:0]  wr_tab,
  input  logic [5:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [TAB_W-1:0]  rd_tab,
  input  logic [5:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [NUM_TAB][64];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int t = 0; t < NUM_TAB; t++)
        for (int a = 0; a < 64; a++)
          mem[t][a] <= DATA_W'(def_val(a));
    end else if (wr_en && 32'(wr_tab) < NUM_TAB) begin
      mem[wr_tab][wr_addr] <= wr_data;
    end
  always_comb rd_data = 32'(rd_tab) < NUM_TAB ? mem[rd_tab][rd_addr] : '0;
endmodule

// File: rtl/qtab_stream.sv
// qtab_stream: writable quantisation tables streamed as 64-beat raster or zig-zag blocks
module qtab_stream import qtab_pkg::*; #(
  parameter int DATA_W = 8,
  parameter int NUM_TAB = 2,
  localparam int TAB_W = NUM_TAB > 1 ? $clog2(NUM_TAB) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [TAB_W-1:0]  wr_tab,
  input  logic [5:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic [TAB_W-1:0]  tab_sel,
  input  logic              zz_mode,
  output logic              busy,
  output logic              q_valid,
  input  logic              q_ready,
  output logic [DATA_W-1:0] q_data,
  output logic [5:0]        q_idx,
  output logic [5:0]        q_addr,
  output logic              q_last
);
  state_t state;
  logic [TAB_W-1:0] tab_r, rd_tab;
  logic zz_r, zz, idle, fetch;
  logic [6:0] pos, p;
  logic [5:0] raddr;
  logic [DATA_W-1:0] rd_data;
  qtab_mem #(.DATA_W(DATA_W), .NUM_TAB(NUM_TAB)) u_mem (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_tab(wr_tab), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_tab(rd_tab), .rd_addr(raddr), .rd_data(rd_data)
  );
  always_comb begin
    idle = state == IDLE;
    p = idle ? 7'd0 : pos;
    zz = idle ? zz_mode : zz_r;
    rd_tab = idle ? tab_sel : tab_r;
    raddr = zz ? ZIGZAG[p[5:0]] : p[5:0];
    fetch = idle ? start : (!pos[6] && (!q_valid || q_ready));
  end
  assign busy = !idle;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tab_r <= '0;
      zz_r <= 1'b0;
      pos <= '0;
      q_valid <= 1'b0;
      q_data <= '0;
      q_idx <= '0;
      q_addr <= '0;
      q_last <= 1'b0;
    end else begin
      if (fetch) begin
        q_valid <= 1'b1;
        q_data <= rd_data;
        q_addr <= raddr;
        q_idx <= p[5:0];
        q_last <= p == 7'd63;
        pos <= p + 7'd1;
      end else if (q_ready) begin
        q_valid <= 1'b0;
      end
      if (idle && start) begin
        state <= RUN;
        tab_r <= tab_sel;
        zz_r <= zz_mode;
      end else if (!idle && q_valid && q_ready && q_last) begin
        state <= IDLE;
      end
    end
endmodule

// File: tb/tb_qtab_stream.sv
// tb_qtab_stream: directed checks of table defaults, scan orders, writes, backpressure and reset abort
module tb_qtab_stream;
  logic clk = 0, rst_n = 0, wr_en = 0, start = 0, zz_mode = 0, q_ready = 1;
  logic [0:0] wr_tab = 0, tab_sel = 0;
  logic [5:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic busy, q_valid, q_last;
  logic [7:0] q_data;
  logic [5:0] q_idx, q_addr;
  int errors = 0, checks = 0;

  localparam logic [7:0] DEF [64] = '{
    8'hFF, 8'h80, 8'h6C, 8'h5D, 8'h4F, 8'h4C, 8'h47, 8'h3C,
    8'h80, 8'h80, 8'h5D, 8'h55, 8'h4C, 8'h47, 8'h3C, 8'h37,
    8'h6C, 8'h5D, 8'h4F, 8'h4C, 8'h47, 8'h3C, 8'h3C, 8'h36,
    8'h5D, 8'h5D, 8'h4F, 8'h4C, 8'h47, 8'h3C, 8'h37, 8'h33,
    8'h5D, 8'h4F, 8'h4C, 8'h47, 8'h40, 8'h3B, 8'h33, 8'h2B,
    8'h4F, 8'h4C, 8'h47, 8'h40, 8'h3B, 8'h33, 8'h2B, 8'h23,
    8'h4F, 8'h4C, 8'h47, 8'h3C, 8'h36, 8'h2D, 8'h25, 8'h1E,
    8'h4C, 8'h47, 8'h3B, 8'h36, 8'h2D, 8'h25, 8'h1E, 8'h19
  };
  localparam int ZZ [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  qtab_stream dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_tab(wr_tab), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .tab_sel(tab_sel), .zz_mode(zz_mode),
    .busy(busy), .q_valid(q_valid), .q_ready(q_ready),
    .q_data(q_data), .q_idx(q_idx), .q_addr(q_addr), .q_last(q_last)
  );

  always #5 clk = ~clk;

  logic [7:0] g_data [64];
  logic [5:0] g_addr [64];
  logic [5:0] g_idx [64];
  logic g_last [64];
  int nb, first_cyc, end_cyc, stall_bad;
  logic busy0, ab_valid, ab_busy;
  logic [7:0] ab_data;

  task automatic stream(input logic t, input logic zz, input bit rnd, input bit disturb,
                        input int wr_cyc, input logic [5:0] wa, input logic [7:0] wd, input int abort_cyc);
    int cyc;
    logic stalled;
    logic [21:0] prev, cur;
    nb = 0; stall_bad = 0; first_cyc = -1; cyc = 0; stalled = 0; prev = '0;
    start = 1; tab_sel = t; zz_mode = zz; q_ready = 1;
    @(negedge clk);
    start = 0;
    busy0 = busy;
    while (nb < 64 && cyc < 1000) begin
      cur = {q_valid, q_last, q_idx, q_addr, q_data};
      if (stalled && cur !== prev) stall_bad++;
      if (cyc == abort_cyc) begin
        rst_n = 0;
        #1;
        ab_valid = q_valid; ab_busy = busy; ab_data = q_data;
        @(negedge clk);
        rst_n = 1; wr_en = 0; q_ready = 1; end_cyc = cyc;
        return;
      end
      q_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wr_en = cyc == wr_cyc; wr_tab = t; wr_addr = wa; wr_data = wd;
      if (disturb) begin
        start = cyc == 10;
        tab_sel = cyc >= 10 ? ~t : t;
        zz_mode = cyc >= 10 ? ~zz : zz;
      end
      if (q_valid && q_ready) begin
        g_data[nb] = q_data; g_addr[nb] = q_addr; g_idx[nb] = q_idx; g_last[nb] = q_last;
        if (nb == 0) first_cyc = cyc;
        nb++;
      end
      stalled = q_valid && !q_ready;
      prev = cur;
      cyc++;
      @(negedge clk);
    end
    wr_en = 0; start = 0; q_ready = 1; end_cyc = cyc;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({busy, q_valid, q_last} !== 3'b000) begin errors++; $display("FAIL reset_flags got busy/valid/last=%b want 000", {busy, q_valid, q_last}); end
    checks++;
    if ({q_data, q_idx, q_addr} !== 20'h0) begin errors++; $display("FAIL reset_data got data=%h idx=%0d addr=%0d want 0", q_data, q_idx, q_addr); end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_raster;
    int bad = 0;
    stream(0, 0, 0, 0, -1, 0, 0, -1);
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL raster_busy1 got %b want 1", busy0); end
    checks++;
    if (nb !== 64 || first_cyc !== 0 || end_cyc !== 64) begin errors++; $display("FAIL raster_timing got beats=%0d first=%0d end=%0d want 64 0 64", nb, first_cyc, end_cyc); end
    checks++;
    if (g_data[0] !== 8'hFF || g_data[7] !== 8'h3C || g_data[63] !== 8'h19) begin errors++; $display("FAIL raster_points got %h %h %h want FF 3C 19", g_data[0], g_data[7], g_data[63]); end
    checks++;
    if (g_last[63] !== 1'b1 || g_last[62] !== 1'b0) begin errors++; $display("FAIL raster_last got %b%b want 01", g_last[62], g_last[63]); end
    for (int i = 0; i < 64; i++) if (g_data[i] !== DEF[i] || g_addr[i] !== 6'(i) || g_idx[i] !== 6'(i)) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL raster_table got %0d bad beats want 0", bad); end
    checks++;
    if (busy !== 1'b0 || q_valid !== 1'b0) begin errors++; $display("FAIL raster_done got busy=%b valid=%b want 0 0", busy, q_valid); end
  endtask

  task automatic test_zigzag;
    int bad = 0;
    stream(0, 1, 0, 0, -1, 0, 0, -1);
    checks++;
    if ({g_addr[0], g_addr[1], g_addr[2], g_addr[3], g_addr[4], g_addr[5]} !== {6'd0, 6'd1, 6'd8, 6'd16, 6'd9, 6'd2}) begin
      errors++; $display("FAIL zz_addr got %0d %0d %0d %0d %0d %0d want 0 1 8 16 9 2", g_addr[0], g_addr[1], g_addr[2], g_addr[3], g_addr[4], g_addr[5]);
    end
    checks++;
    if ({g_data[0], g_data[1], g_data[2], g_data[3], g_data[4], g_data[5]} !== 48'hFF80806C806C) begin
      errors++; $display("FAIL zz_data got %h %h %h %h %h %h want FF 80 80 6C 80 6C", g_data[0], g_data[1], g_data[2], g_data[3], g_data[4], g_data[5]);
    end
    checks++;
    if (g_addr[63] !== 6'd63 || g_data[63] !== 8'h19 || g_last[63] !== 1'b1) begin errors++; $display("FAIL zz_last got addr=%0d data=%h last=%b want 63 19 1", g_addr[63], g_data[63], g_last[63]); end
    for (int i = 0; i < 64; i++) if (g_addr[i] !== 6'(ZZ[i]) || g_data[i] !== DEF[ZZ[i]] || g_idx[i] !== 6'(i)) bad++;
    checks++;
    if (nb !== 64 || bad != 0) begin errors++; $display("FAIL zz_table got beats=%0d bad=%0d want 64 0", nb, bad); end
  endtask

  task automatic test_write;
    int bad = 0;
    wr_en = 1; wr_tab = 1; wr_addr = 0; wr_data = 8'h11;
    @(negedge clk);
    wr_en = 0;
    stream(1, 0, 0, 0, -1, 0, 0, -1);
    checks++;
    if (g_data[0] !== 8'h11) begin errors++; $display("FAIL wr_tab1 got %h want 11", g_data[0]); end
    for (int i = 1; i < 64; i++) if (g_data[i] !== DEF[i]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wr_tab1_rest got %0d bad want 0", bad); end
    stream(0, 0, 0, 0, -1, 0, 0, -1);
    checks++;
    if (g_data[0] !== 8'hFF) begin errors++; $display("FAIL wr_tab0 got %h want FF", g_data[0]); end
  endtask

  task automatic test_backpressure;
    int bad = 0;
    stream(0, 0, 1, 0, -1, 0, 0, -1);
    for (int i = 0; i < 64; i++) if (g_idx[i] !== 6'(i) || g_data[i] !== DEF[i]) bad++;
    checks++;
    if (nb !== 64 || bad != 0) begin errors++; $display("FAIL bp_order got beats=%0d bad=%0d want 64 0", nb, bad); end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d changes while stalled want 0", stall_bad); end
    checks++;
    if (busy !== 1'b0 || q_valid !== 1'b0) begin errors++; $display("FAIL bp_done got busy=%b valid=%b want 0 0", busy, q_valid); end
  endtask

  task automatic test_busy_ignore;
    int bad = 0;
    stream(0, 0, 0, 1, -1, 0, 0, -1);
    for (int i = 0; i < 64; i++) if (g_addr[i] !== 6'(i) || g_data[i] !== DEF[i]) bad++;
    checks++;
    if (nb !== 64 || end_cyc !== 64 || bad != 0) begin errors++; $display("FAIL ign_block got beats=%0d end=%0d bad=%0d want 64 64 0", nb, end_cyc, bad); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || q_valid !== 1'b0) begin errors++; $display("FAIL ign_restart got busy=%b valid=%b want 0 0", busy, q_valid); end
  endtask

  task automatic test_collide_and_abort;
    stream(0, 0, 0, 0, 4, 6'd5, 8'h99, -1);
    checks++;
    if (g_data[5] !== 8'h4C || g_data[4] !== 8'h4F) begin errors++; $display("FAIL col_old got %h %h want 4F 4C", g_data[4], g_data[5]); end
    stream(0, 0, 0, 0, -1, 0, 0, -1);
    checks++;
    if (g_data[5] !== 8'h99) begin errors++; $display("FAIL col_new got %h want 99", g_data[5]); end
    stream(0, 0, 0, 0, -1, 0, 0, 20);
    checks++;
    if (ab_valid !== 1'b0 || ab_busy !== 1'b0 || ab_data !== 8'h00) begin errors++; $display("FAIL abort got valid=%b busy=%b data=%h want 0 0 00", ab_valid, ab_busy, ab_data); end
    stream(0, 0, 0, 0, -1, 0, 0, -1);
    checks++;
    if (nb !== 64 || g_data[5] !== 8'h4C || g_data[0] !== 8'hFF) begin errors++; $display("FAIL abort_t0 got beats=%0d d0=%h d5=%h want 64 FF 4C", nb, g_data[0], g_data[5]); end
    stream(1, 0, 0, 0, -1, 0, 0, -1);
    checks++;
    if (g_data[0] !== 8'hFF) begin errors++; $display("FAIL abort_t1 got %h want FF", g_data[0]); end
  endtask

  initial begin
    test_reset;
    test_raster;
    test_zigzag;
    test_write;
    test_backpressure;
    test_busy_ignore;
    test_collide_and_abort;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
